// File: rtl/serial_subtractor_if.sv
// Handshake bundle for serial_subtractor: operand side (in_*) and result side (out_*, diff, bout).
interface serial_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             bin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             bout;

    modport master (
        output in_valid, in_a, in_b, bin, out_ready,
        input  in_ready, out_valid, diff, bout
    );

    modport slave (
        input  in_valid, in_a, in_b, bin, out_ready,
        output in_ready, out_valid, diff, bout
    );
endinterface

// File: rtl/serial_subtractor.sv
// Multi-cycle unsigned subtractor: a - b - bin, CHUNK bits per clock, LSB chunk first.
// Define SERIAL_SUBTRACTOR_SAT_EN to clamp the difference to 0 whenever the final borrow is set.
module serial_subtractor #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    serial_subtractor_if.slave  bus
);
    localparam int N     = WIDTH / CHUNK;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] diff_q;
    logic             borrow_q;
    logic             bout_q;

    logic [CHUNK-1:0] a_chunk;
    logic [CHUNK-1:0] b_chunk;
    logic [CHUNK:0]   chunk_full;
    logic [CHUNK-1:0] chunk_diff;
    logic             chunk_borrow;
    logic [WIDTH-1:0] acc_next;
    logic [WIDTH-1:0] result;
    logic             accept;
    logic             last_chunk;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.in_valid) state_d = BUSY;
            BUSY:    if (cnt_q == LAST) state_d = DONE;
            DONE:    if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // One chunk of the borrow chain: the extra top bit of the widened difference is the borrow out.
    always_comb begin
        a_chunk      = a_q[int'(cnt_q) * CHUNK +: CHUNK];
        b_chunk      = b_q[int'(cnt_q) * CHUNK +: CHUNK];
        chunk_full   = {1'b0, a_chunk} - {1'b0, b_chunk} - {{CHUNK{1'b0}}, borrow_q};
        chunk_diff   = chunk_full[CHUNK-1:0];
        chunk_borrow = chunk_full[CHUNK];
        acc_next     = acc_q;
        acc_next[int'(cnt_q) * CHUNK +: CHUNK] = chunk_diff;
        accept       = (state_q == IDLE) && bus.in_valid;
        last_chunk   = (state_q == BUSY) && (cnt_q == LAST);
`ifdef SERIAL_SUBTRACTOR_SAT_EN
        result       = chunk_borrow ? '0 : acc_next;
`else
        result       = acc_next;
`endif
    end

    // The visible diff/bout only change on the last chunk, so partial results never leak out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            borrow_q <= 1'b0;
            diff_q   <= '0;
            bout_q   <= 1'b0;
        end else if (accept) begin
            a_q      <= bus.in_a;
            b_q      <= bus.in_b;
            borrow_q <= bus.bin;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else if (state_q == BUSY) begin
            acc_q    <= acc_next;
            borrow_q <= chunk_borrow;
            if (last_chunk) begin
                cnt_q  <= '0;
                diff_q <= result;
                bout_q <= chunk_borrow;
            end else begin
                cnt_q  <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.diff      = diff_q;
    assign bus.bout      = bout_q;
endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: three instances (CHUNK 2, 1, 8) checked every cycle against an arithmetic model.
module tb_serial_subtractor;
    logic clk;
    logic rst_n;

    logic       drv_valid [3];
    logic       drv_bin   [3];
    logic       drv_ready [3];
    logic [7:0] drv_a     [3];
    logic [7:0] drv_b     [3];
    logic       mon_in_ready  [3];
    logic       mon_out_valid [3];
    logic       mon_bout      [3];
    logic [7:0] mon_diff      [3];

    int  tests_run;
    int  tests_failed;
    bit  check_en;
    bit  rand_run;

`ifdef SERIAL_SUBTRACTOR_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    serial_subtractor_if #(.WIDTH(8)) bus_c2 ();
    serial_subtractor_if #(.WIDTH(8)) bus_c1 ();
    serial_subtractor_if #(.WIDTH(8)) bus_c8 ();

    assign bus_c2.in_valid  = drv_valid[0];
    assign bus_c2.in_a      = drv_a[0];
    assign bus_c2.in_b      = drv_b[0];
    assign bus_c2.bin       = drv_bin[0];
    assign bus_c2.out_ready = drv_ready[0];
    assign mon_in_ready[0]  = bus_c2.in_ready;
    assign mon_out_valid[0] = bus_c2.out_valid;
    assign mon_diff[0]      = bus_c2.diff;
    assign mon_bout[0]      = bus_c2.bout;

    assign bus_c1.in_valid  = drv_valid[1];
    assign bus_c1.in_a      = drv_a[1];
    assign bus_c1.in_b      = drv_b[1];
    assign bus_c1.bin       = drv_bin[1];
    assign bus_c1.out_ready = drv_ready[1];
    assign mon_in_ready[1]  = bus_c1.in_ready;
    assign mon_out_valid[1] = bus_c1.out_valid;
    assign mon_diff[1]      = bus_c1.diff;
    assign mon_bout[1]      = bus_c1.bout;

    assign bus_c8.in_valid  = drv_valid[2];
    assign bus_c8.in_a      = drv_a[2];
    assign bus_c8.in_b      = drv_b[2];
    assign bus_c8.bin       = drv_bin[2];
    assign bus_c8.out_ready = drv_ready[2];
    assign mon_in_ready[2]  = bus_c8.in_ready;
    assign mon_out_valid[2] = bus_c8.out_valid;
    assign mon_diff[2]      = bus_c8.diff;
    assign mon_bout[2]      = bus_c8.bout;

    serial_subtractor #(.WIDTH(8), .CHUNK(2)) u_dut_c2 (.clk(clk), .rst_n(rst_n), .bus(bus_c2));
    serial_subtractor #(.WIDTH(8), .CHUNK(1)) u_dut_c1 (.clk(clk), .rst_n(rst_n), .bus(bus_c1));
    serial_subtractor #(.WIDTH(8), .CHUNK(8)) u_dut_c8 (.clk(clk), .rst_n(rst_n), .bus(bus_c8));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #600000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, expected to have finished", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic int latOf(input int k);
        return (k == 0) ? 4 : (k == 1) ? 8 : 1;
    endfunction

    // Golden result as plain integer arithmetic: {bout, diff}.
    function automatic logic [8:0] golden(input logic [7:0] a, input logic [7:0] b, input logic bi);
        int         d;
        logic [8:0] r;
        d       = int'(a) - int'(b) - int'(bi);
        r[8]    = (d < 0);
        r[7:0]  = d[7:0];
        if (SAT && d < 0) r[7:0] = 8'd0;
        return r;
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        tests_run++;
        if (actual != expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    bit         m_busy   [3];
    bit         acc_pend [3];
    bit         rel_pend [3];
    int         m_age    [3];
    logic [8:0] m_res    [3];
    logic [8:0] m_show   [3];

    // Model: an accepted op becomes visible latOf(k) cycles later and stays until consumed.
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            bit exp_ready;
            bit exp_valid;
            if (!rst_n) begin
                m_busy[k]   = 1'b0;
                m_age[k]    = 0;
                m_show[k]   = 9'd0;
                acc_pend[k] = 1'b0;
                rel_pend[k] = 1'b0;
            end else if (rel_pend[k]) begin
                m_busy[k] = 1'b0;
            end else if (acc_pend[k]) begin
                m_busy[k] = 1'b1;
                m_age[k]  = 0;
            end else if (m_busy[k] && m_age[k] < latOf(k)) begin
                m_age[k]++;
                if (m_age[k] == latOf(k)) m_show[k] = m_res[k];
            end
            exp_ready = !m_busy[k];
            exp_valid = m_busy[k] && (m_age[k] >= latOf(k));
            if (check_en) begin
                checkOutput($sformatf("u%0d_in_ready", k),  int'(mon_in_ready[k]),  int'(exp_ready));
                checkOutput($sformatf("u%0d_out_valid", k), int'(mon_out_valid[k]), int'(exp_valid));
                checkOutput($sformatf("u%0d_diff", k),      int'(mon_diff[k]),      int'(m_show[k][7:0]));
                checkOutput($sformatf("u%0d_bout", k),      int'(mon_bout[k]),      int'(m_show[k][8]));
            end
            acc_pend[k] = rst_n && exp_ready && drv_valid[k];
            rel_pend[k] = rst_n && exp_valid && drv_ready[k];
            if (acc_pend[k]) m_res[k] = golden(drv_a[k], drv_b[k], drv_bin[k]);
        end
    end

    // Presents one operation and holds it until the accepting edge has passed.
    task automatic applyStimulus(input int k, input logic [7:0] a, input logic [7:0] b, input logic bi);
        int guard;
        guard = 0;
        @(posedge clk);
        #1;
        drv_a[k]     = a;
        drv_b[k]     = b;
        drv_bin[k]   = bi;
        drv_valid[k] = 1'b1;
        @(negedge clk);
        while (!mon_in_ready[k] && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!mon_in_ready[k]) begin
            checkOutput("accept_timeout", 0, 1);
            drv_valid[k] = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            drv_valid[k] = 1'b0;
        end
    endtask

    task automatic waitResult(input int k, output int lat);
        lat = 0;
        @(negedge clk);
        while (!mon_out_valid[k] && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic releaseResult(input int k);
        @(posedge clk);
        #1;
        drv_ready[k] = 1'b1;
        @(posedge clk);
        #1;
        drv_ready[k] = 1'b0;
        checkOutput("in_ready_after_release", int'(mon_in_ready[k]), 1);
    endtask

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       bi;
        logic [7:0] d;
        logic       bo;
    } vec_t;

    vec_t vecs[$];

    initial begin
        int lat;
        int exp_d;
        tests_run    = 0;
        tests_failed = 0;
        check_en     = 1'b0;
        rand_run     = 1'b0;
        rst_n        = 1'b0;
        for (int k = 0; k < 3; k++) begin
            drv_valid[k] = 1'b0;
            drv_ready[k] = 1'b0;
            drv_bin[k]   = 1'b0;
            drv_a[k]     = 8'd0;
            drv_b[k]     = 8'd0;
        end

        vecs.push_back('{8'd200, 8'd37,  1'b0, 8'd163, 1'b0});
        vecs.push_back('{8'd5,   8'd9,   1'b0, 8'd252, 1'b1});
        vecs.push_back('{8'd0,   8'd0,   1'b1, 8'd255, 1'b1});
        vecs.push_back('{8'd255, 8'd255, 1'b1, 8'd255, 1'b1});
        vecs.push_back('{8'd128, 8'd127, 1'b1, 8'd0,   1'b0});
        vecs.push_back('{8'd255, 8'd0,   1'b0, 8'd255, 1'b0});
        vecs.push_back('{8'd77,  8'd77,  1'b0, 8'd0,   1'b0});

        repeat (3) @(posedge clk);
        #1;
        check_en = 1'b1;
        checkOutput("reset_in_ready",  int'(mon_in_ready[0]),  1);
        checkOutput("reset_out_valid", int'(mon_out_valid[0]), 0);
        checkOutput("reset_diff",      int'(mon_diff[0]),      0);
        checkOutput("reset_bout",      int'(mon_bout[0]),      0);
        rst_n = 1'b1;

        $display("[TB] directed vectors, CHUNK=2");
        foreach (vecs[i]) begin
            applyStimulus(0, vecs[i].a, vecs[i].b, vecs[i].bi);
            waitResult(0, lat);
            exp_d = (SAT && vecs[i].bo) ? 0 : int'(vecs[i].d);
            checkOutput($sformatf("lat_%0d_%0d", vecs[i].a, vecs[i].b), lat, 4);
            checkOutput($sformatf("diff_%0d_%0d", vecs[i].a, vecs[i].b), int'(mon_diff[0]), exp_d);
            checkOutput($sformatf("bout_%0d_%0d", vecs[i].a, vecs[i].b), int'(mon_bout[0]), int'(vecs[i].bo));
            releaseResult(0);
        end

        $display("[TB] backpressure with input churn");
        applyStimulus(0, 8'd200, 8'd37, 1'b0);
        waitResult(0, lat);
        for (int c = 0; c < 6; c++) begin
            @(posedge clk);
            #1;
            drv_a[0]     = 8'($urandom);
            drv_b[0]     = 8'($urandom);
            drv_bin[0]   = 1'($urandom_range(0, 1));
            drv_valid[0] = ~drv_valid[0];
            checkOutput("hold_diff",      int'(mon_diff[0]),      163);
            checkOutput("hold_bout",      int'(mon_bout[0]),      0);
            checkOutput("hold_in_ready",  int'(mon_in_ready[0]),  0);
            checkOutput("hold_out_valid", int'(mon_out_valid[0]), 1);
        end
        drv_valid[0] = 1'b0;
        releaseResult(0);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("idle_hold_diff", int'(mon_diff[0]), 163);

        $display("[TB] reset during BUSY");
        applyStimulus(0, 8'd50, 8'd20, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("abort_out_valid", int'(mon_out_valid[0]), 0);
        checkOutput("abort_diff",      int'(mon_diff[0]),      0);
        checkOutput("abort_bout",      int'(mon_bout[0]),      0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("abort_in_ready", int'(mon_in_ready[0]), 1);
        applyStimulus(0, 8'd10, 8'd3, 1'b0);
        waitResult(0, lat);
        checkOutput("post_abort_lat",  lat, 4);
        checkOutput("post_abort_diff", int'(mon_diff[0]), 7);
        checkOutput("post_abort_bout", int'(mon_bout[0]), 0);
        releaseResult(0);

        $display("[TB] CHUNK=1 and CHUNK=8 latency");
        applyStimulus(1, 8'd200, 8'd37, 1'b0);
        waitResult(1, lat);
        checkOutput("c1_lat",  lat, 8);
        checkOutput("c1_diff", int'(mon_diff[1]), 163);
        releaseResult(1);
        applyStimulus(2, 8'd5, 8'd9, 1'b0);
        waitResult(2, lat);
        checkOutput("c8_lat",  lat, 1);
        checkOutput("c8_diff", int'(mon_diff[2]), SAT ? 0 : 252);
        checkOutput("c8_bout", int'(mon_bout[2]), 1);
        releaseResult(2);

        $display("[TB] random operations with handshake gaps");
        for (int k = 0; k < 3; k++) begin
            rand_run = 1'b1;
            fork
                begin
                    while (rand_run) begin
                        @(posedge clk);
                        #1;
                        drv_ready[k] = ($urandom_range(0, 2) != 0);
                    end
                    drv_ready[k] = 1'b1;
                end
                begin
                    for (int n = 0; n < 100; n++) begin
                        repeat ($urandom_range(0, 2)) @(posedge clk);
                        applyStimulus(k, 8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
                    end
                    rand_run = 1'b0;
                end
            join
            repeat (latOf(k) + 4) @(posedge clk);
            #1;
            drv_ready[k] = 1'b0;
        end

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
